// File: rtl/deser_pkg.sv
// Shared types and constants for the N-bit lane deserializer.
package deser_pkg;

   typedef enum logic [1:0] {
      HUNT,
      CHECK,
      LOCKED
   } deser_state_t;

   // 4b/5b-style idle word, MSB first; none of its rotations equal itself
   localparam logic [4:0] SYNC_4B5B = 5'b11000;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/deser_nbit_align_if.sv
// Lane-side serial input and decoder-side parallel output of the deserializer.
interface deser_nbit_align_if #(parameter int WIDTH = 5);

   logic             sdata;
   logic             realign;
   logic [WIDTH-1:0] pdata;
   logic             pvalid;
   logic             locked;
   logic [7:0]       slip_count;

   modport master (
      output sdata, realign,
      input  pdata, pvalid, locked, slip_count
   );

   modport slave (
      input  sdata, realign,
      output pdata, pvalid, locked, slip_count
   );

endinterface

// File: rtl/deser_phase_ctr.sv
// Word phase counter: strobes every WIDTH edges; a slip stalls it one edge to move the boundary.
module deser_phase_ctr #(
   parameter int WIDTH = 5
) (
   input  logic clk160,
   input  logic reset,
   input  logic slip,
   output logic strobe
);

   localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

   logic [PW-1:0] phase;
   logic          hold;

   assign strobe = (phase == LAST) && !hold;

   // A slip can only come on a strobe edge, so hold always freezes phase at 0
   always_ff @(posedge clk160 or posedge reset) begin
      if (reset) begin
         phase <= '0;
         hold  <= 1'b0;
      end else if (hold) begin
         hold <= 1'b0;
      end else begin
         hold <= slip;
         if (phase == LAST)
            phase <= '0;
         else
            phase <= phase + 1'b1;
      end
   end

endmodule

// File: rtl/deser_nbit_align.sv
// Serial-to-parallel deserializer with bit-slip word alignment against a sync pattern and lock FSM.
module deser_nbit_align
   import deser_pkg::*;
#(
   parameter int               WIDTH        = 5,
   parameter logic [WIDTH-1:0] SYNC_PATTERN = SYNC_4B5B,
   parameter int               LOCK_COUNT   = 4
) (
   input logic               clk160,
   input logic               reset,
   deser_nbit_align_if.slave bus
);

   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] word;
   logic             strobe;
   logic             slip;
   logic             match;

   deser_state_t state, state_n;
   logic [3:0]   cnt, cnt_n;

   logic [WIDTH-1:0] pdata_r;
   logic             pvalid_r;
   logic             locked_r;
   logic [7:0]       slip_count_r;

   // The word includes the bit sampled on this edge, so capture has no extra latency
   assign word  = {shreg[WIDTH-2:0], bus.sdata};
   assign match = (word == SYNC_PATTERN);

   deser_phase_ctr #(.WIDTH(WIDTH)) u_phase (
      .clk160 (clk160),
      .reset  (reset),
      .slip   (slip),
      .strobe (strobe)
   );

   always_ff @(posedge clk160 or posedge reset) begin
      if (reset) begin
         shreg <= '0;
         state <= HUNT;
         cnt   <= '0;
      end else begin
         shreg <= word;
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // realign wins over any strobe-edge transition and never slips
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      slip    = 1'b0;
      if (bus.realign) begin
         state_n = HUNT;
         cnt_n   = '0;
      end else if (strobe) begin
         case (state)
            HUNT: begin
               if (match) begin
                  cnt_n   = 4'd1;
                  state_n = (LOCK_COUNT == 1) ? LOCKED : CHECK;
               end else begin
                  slip = 1'b1;
               end
            end
            CHECK: begin
               if (match) begin
                  cnt_n = cnt + 4'd1;
                  if (cnt + 4'd1 == 4'(LOCK_COUNT))
                     state_n = LOCKED;
               end else begin
                  slip    = 1'b1;
                  state_n = HUNT;
                  cnt_n   = '0;
               end
            end
            LOCKED: ;
            default: begin
               state_n = HUNT;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk160 or posedge reset) begin
      if (reset) begin
         pdata_r      <= '0;
         pvalid_r     <= 1'b0;
         locked_r     <= 1'b0;
         slip_count_r <= '0;
      end else begin
         if (strobe)
            pdata_r <= word;
         pvalid_r <= strobe && (state == LOCKED) && !bus.realign;
         locked_r <= (state_n == LOCKED);
         if (slip)
            slip_count_r <= sat_inc8(slip_count_r);
      end
   end

   assign bus.pdata      = pdata_r;
   assign bus.pvalid     = pvalid_r;
   assign bus.locked     = locked_r;
   assign bus.slip_count = slip_count_r;

endmodule

// File: tb/tb_deser_nbit_align.sv
// Directed bench for deser_nbit_align: word table for lock/data/realign plus slip, reset and saturation sequences.
module tb_deser_nbit_align;

   logic clk160;
   logic reset;

   int testCount;
   int failCount;

   logic [4:0] syncWord;

   typedef struct {
      logic [4:0] word;
      logic       realignLast;
      logic       expValid;
      logic [4:0] expData;
      logic       expLocked;
   } vecT;

   vecT vecs[13];

   deser_nbit_align_if #(.WIDTH(5)) bus ();

   deser_nbit_align #(
      .WIDTH        (5),
      .SYNC_PATTERN (5'b11000),
      .LOCK_COUNT   (4)
   ) dut (
      .clk160 (clk160),
      .reset  (reset),
      .bus    (bus)
   );

   initial clk160 = 1'b0;
   always #5 clk160 = ~clk160;

   // Drives one serial bit, lets one rising edge consume it, returns 1 time unit later
   task automatic applyStimulus(input logic b, input logic rl);
      bus.sdata   = b;
      bus.realign = rl;
      @(posedge clk160);
      #1;
      bus.realign = 1'b0;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      testCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic sendWord(input logic [4:0] w);
      for (int i = 4; i >= 0; i--)
         applyStimulus(w[i], 1'b0);
   endtask

   task automatic resetDut();
      reset       = 1'b1;
      bus.sdata   = 1'b0;
      bus.realign = 1'b0;
      repeat (3) @(posedge clk160);
      @(negedge clk160);
      reset = 1'b0;
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      syncWord  = 5'b11000;

      vecs[0]  = '{5'b11000, 1'b0, 1'b0, 5'b11000, 1'b0};
      vecs[1]  = '{5'b11000, 1'b0, 1'b0, 5'b11000, 1'b0};
      vecs[2]  = '{5'b11000, 1'b0, 1'b0, 5'b11000, 1'b0};
      vecs[3]  = '{5'b11000, 1'b0, 1'b0, 5'b11000, 1'b1};
      vecs[4]  = '{5'b11000, 1'b0, 1'b1, 5'b11000, 1'b1};
      vecs[5]  = '{5'b10101, 1'b0, 1'b1, 5'b10101, 1'b1};
      vecs[6]  = '{5'b00111, 1'b0, 1'b1, 5'b00111, 1'b1};
      vecs[7]  = '{5'b11000, 1'b1, 1'b0, 5'b11000, 1'b0};
      vecs[8]  = '{5'b11000, 1'b0, 1'b0, 5'b11000, 1'b0};
      vecs[9]  = '{5'b11000, 1'b0, 1'b0, 5'b11000, 1'b0};
      vecs[10] = '{5'b11000, 1'b0, 1'b0, 5'b11000, 1'b0};
      vecs[11] = '{5'b11000, 1'b0, 1'b0, 5'b11000, 1'b1};
      vecs[12] = '{5'b11000, 1'b0, 1'b1, 5'b11000, 1'b1};

      // Reset state, sampled while reset is held
      reset       = 1'b1;
      bus.sdata   = 1'b0;
      bus.realign = 1'b0;
      #12;
      checkOutput("reset pdata", int'(bus.pdata), 0);
      checkOutput("reset pvalid", int'(bus.pvalid), 0);
      checkOutput("reset locked", int'(bus.locked), 0);
      checkOutput("reset slip_count", int'(bus.slip_count), 0);

      // Aligned stream, data while locked, realign on a strobe and re-lock
      resetDut();
      for (int v = 0; v < 13; v++) begin
         for (int i = 4; i >= 0; i--) begin
            applyStimulus(vecs[v].word[i], (i == 0) ? vecs[v].realignLast : 1'b0);
            if (i == 4)
               checkOutput($sformatf("vec%0d pvalid mid-word", v), int'(bus.pvalid), 0);
         end
         checkOutput($sformatf("vec%0d pvalid", v), int'(bus.pvalid), int'(vecs[v].expValid));
         checkOutput($sformatf("vec%0d pdata", v), int'(bus.pdata), int'(vecs[v].expData));
         checkOutput($sformatf("vec%0d locked", v), int'(bus.locked), int'(vecs[v].expLocked));
         checkOutput($sformatf("vec%0d slip_count", v), int'(bus.slip_count), 0);
      end

      // Stream starting at pattern bit 2: three slips, lock after edge 38
      resetDut();
      for (int n = 1; n <= 43; n++) begin
         applyStimulus(syncWord[4 - ((n - 1 + 2) % 5)], 1'b0);
         if (n == 5)
            checkOutput("k2 first slip", int'(bus.slip_count), 1);
         if (n == 37)
            checkOutput("k2 locked before 38", int'(bus.locked), 0);
         if (n == 38) begin
            checkOutput("k2 locked at 38", int'(bus.locked), 1);
            checkOutput("k2 slip_count", int'(bus.slip_count), 3);
         end
         if (n == 43) begin
            checkOutput("k2 pvalid", int'(bus.pvalid), 1);
            checkOutput("k2 pdata", int'(bus.pdata), 5'b11000);
         end
      end

      // Corrupted word while in CHECK with cnt=3, then one inserted bit realigns
      resetDut();
      repeat (3) sendWord(5'b11000);
      sendWord(5'b11001);
      checkOutput("corrupt slip_count", int'(bus.slip_count), 1);
      checkOutput("corrupt locked", int'(bus.locked), 0);
      checkOutput("corrupt pdata", int'(bus.pdata), 5'b11001);
      applyStimulus(1'b0, 1'b0);
      repeat (3) sendWord(5'b11000);
      checkOutput("relock not yet", int'(bus.locked), 0);
      sendWord(5'b11000);
      checkOutput("relock after 4", int'(bus.locked), 1);
      checkOutput("relock slip_count", int'(bus.slip_count), 1);

      // Asynchronous reset mid-word while locked
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("async pdata", int'(bus.pdata), 0);
      checkOutput("async pvalid", int'(bus.pvalid), 0);
      checkOutput("async locked", int'(bus.locked), 0);
      checkOutput("async slip_count", int'(bus.slip_count), 0);
      repeat (2) @(negedge clk160);
      reset = 1'b0;
      repeat (3) sendWord(5'b11000);
      checkOutput("post-reset locked early", int'(bus.locked), 0);
      sendWord(5'b11000);
      checkOutput("post-reset locked at 20", int'(bus.locked), 1);
      checkOutput("post-reset slip_count", int'(bus.slip_count), 0);

      // All-zero noise never matches: slip every 6 edges until saturation
      resetDut();
      for (int n = 1; n <= 1800; n++) begin
         applyStimulus(1'b0, 1'b0);
         if (n == 1523)
            checkOutput("noise slip 254", int'(bus.slip_count), 254);
         if (n == 1529)
            checkOutput("noise slip 255", int'(bus.slip_count), 255);
      end
      checkOutput("noise saturated", int'(bus.slip_count), 255);
      checkOutput("noise locked", int'(bus.locked), 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
